// File: rtl/env_mailbox_ram_if.sv
// Port bundle for env_mailbox_ram: both data ports, the clear/step controls
// and the status outputs. The slave modport is the RAM's view; the master
// modport is the view of whoever drives it (host plus environment cores).
interface env_mailbox_ram_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 48
);
  logic                  i_clear;
  logic                  i_we_a;
  logic [ADDR_WIDTH-1:0] i_addr_a;
  logic [DATA_WIDTH-1:0] i_data_a;
  logic [DATA_WIDTH-1:0] o_data_a;
  logic                  i_we_b;
  logic [ADDR_WIDTH-1:0] i_addr_b;
  logic [DATA_WIDTH-1:0] i_data_b;
  logic [DATA_WIDTH-1:0] o_data_b;
  logic                  i_step_done;
  logic                  o_busy;
  logic                  o_run;
  logic                  o_start;
  logic                  o_all_done;
  logic                  o_collision;
  logic                  o_addr_err;

  modport slave (
    input  i_clear, i_we_a, i_addr_a, i_data_a, i_we_b, i_addr_b, i_data_b, i_step_done,
    output o_data_a, o_data_b, o_busy, o_run, o_start, o_all_done, o_collision, o_addr_err
  );

  modport master (
    output i_clear, i_we_a, i_addr_a, i_data_a, i_we_b, i_addr_b, i_data_b, i_step_done,
    input  o_data_a, o_data_b, o_busy, o_run, o_start, o_all_done, o_collision, o_addr_err
  );
endinterface

// File: rtl/env_mailbox_ram.sv
// Dual-port mailbox RAM between the host (port A) and the environment cores
// (port B). Adds a START doorbell register, a done-bit shadow with an
// all-done aggregator, a sequential clear sweep, port-A-wins collision
// handling and out-of-range address detection. Reads are read-first with a
// one-cycle registered latency.
module env_mailbox_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 48,
  parameter int DEPTH      = 2600,
  parameter int ENV_NUM    = 64,
  parameter int STA_WD_NUM = 1,
  parameter int OBS_WD_NUM = 1,
  parameter int ACT_WL     = 2,
  parameter int RWD_WL     = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  env_mailbox_ram_if.slave bus
);

  // Region layout; action and reward bits are packed, hence the ceil divisions.
  localparam int ACT_BASE   = ENV_NUM * STA_WD_NUM;
  localparam int ACT_WORDS  = (ENV_NUM * ACT_WL + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int START_ADDR = ACT_BASE + ACT_WORDS;
  localparam int OBS_BASE   = START_ADDR + 1;
  localparam int RWD_BASE   = OBS_BASE + ENV_NUM * OBS_WD_NUM;
  localparam int RWD_WORDS  = (ENV_NUM * RWD_WL + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int DONE_BASE  = RWD_BASE + RWD_WORDS;
  localparam int DONE_WORDS = (ENV_NUM + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int SH_W       = DONE_WORDS * DATA_WIDTH;
  localparam int CNT_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] START_W = ADDR_WIDTH'(START_ADDR);
  localparam logic [CNT_W-1:0]      LAST_W  = CNT_W'(DEPTH - 1);

  generate
    if (DEPTH < DONE_BASE + DONE_WORDS) begin : g_depth_chk
      $error("env_mailbox_ram: DEPTH too small for the mailbox layout");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  busy;
  logic [CNT_W-1:0]      sweep_cnt;
  logic                  run;
  logic                  start_pulse;
  logic                  collision;
  logic                  addr_err;
  logic                  all_done;
  logic [SH_W-1:0]       shadow;
  logic [DATA_WIDTH-1:0] rdata_a;
  logic [DATA_WIDTH-1:0] rdata_b;

  logic                  in_a;
  logic                  in_b;
  logic                  coll_hit;
  logic                  wr_a;
  logic                  wr_b;
  logic                  start_hit;
  logic                  run_next;
  logic [SH_W-1:0]       shadow_next;
  logic                  all_done_next;

  // Access qualification: range checks, collision arbitration, doorbell.
  always_comb begin
    in_a      = ({1'b0, bus.i_addr_a} < DEPTH_W);
    in_b      = ({1'b0, bus.i_addr_b} < DEPTH_W);
    coll_hit  = !busy && bus.i_we_a && bus.i_we_b && in_a && (bus.i_addr_a == bus.i_addr_b);
    wr_a      = !busy && bus.i_we_a && in_a && (bus.i_addr_a != START_W);
    // Port B loses a same-address collision, so its write is simply dropped.
    wr_b      = !busy && bus.i_we_b && in_b && (bus.i_addr_b != START_W) && !coll_hit;
    start_hit = !busy && bus.i_we_a && in_a && (bus.i_addr_a == START_W) &&
                bus.i_data_a[0] && !run;
    if (start_hit) begin
      run_next = 1'b1;
    end else if (bus.i_step_done) begin
      run_next = 1'b0;
    end else begin
      run_next = run;
    end
  end

  // Next done shadow: cleared on a step launch, then overlaid by DONE-region writes.
  always_comb begin
    if (start_hit) begin
      shadow_next = '0;
    end else begin
      shadow_next = shadow;
    end
    for (int w = 0; w < DONE_WORDS; w++) begin
      if (wr_b && (bus.i_addr_b == ADDR_WIDTH'(DONE_BASE + w))) begin
        shadow_next[w*DATA_WIDTH +: DATA_WIDTH] = bus.i_data_b;
      end else begin
        shadow_next[w*DATA_WIDTH +: DATA_WIDTH] = shadow_next[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // Port A is applied last so it takes precedence.
    for (int w = 0; w < DONE_WORDS; w++) begin
      if (wr_a && (bus.i_addr_a == ADDR_WIDTH'(DONE_BASE + w))) begin
        shadow_next[w*DATA_WIDTH +: DATA_WIDTH] = bus.i_data_a;
      end else begin
        shadow_next[w*DATA_WIDTH +: DATA_WIDTH] = shadow_next[w*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    all_done_next = &shadow_next[ENV_NUM-1:0];
  end

  // Clear sweep sequencer: busy from reset or i_clear until DEPTH words are zeroed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy      <= 1'b1;
      sweep_cnt <= '0;
    end else if (busy) begin
      if (sweep_cnt == LAST_W) begin
        busy      <= 1'b0;
        sweep_cnt <= '0;
      end else begin
        sweep_cnt <= sweep_cnt + CNT_W'(1);
      end
    end else if (bus.i_clear) begin
      busy      <= 1'b1;
      sweep_cnt <= '0;
    end else begin
      sweep_cnt <= sweep_cnt;
    end
  end

  // Control/status registers: run flag, done shadow and one-cycle event pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run         <= 1'b0;
      start_pulse <= 1'b0;
      collision   <= 1'b0;
      addr_err    <= 1'b0;
      shadow      <= '0;
      all_done    <= 1'b0;
    end else begin
      collision <= coll_hit;
      addr_err  <= !(in_a && in_b);
      if (busy || bus.i_clear) begin
        run         <= 1'b0;
        start_pulse <= 1'b0;
        shadow      <= '0;
        all_done    <= 1'b0;
      end else begin
        run         <= run_next;
        start_pulse <= start_hit;
        shadow      <= shadow_next;
        all_done    <= all_done_next;
      end
    end
  end

  // Storage array: the sweep owns the write path while busy, else both ports write.
  always_ff @(posedge i_clk) begin
    if (busy) begin
      mem[sweep_cnt] <= '0;
    end else begin
      if (wr_a) begin
        mem[bus.i_addr_a] <= bus.i_data_a;
      end
      if (wr_b) begin
        mem[bus.i_addr_b] <= bus.i_data_b;
      end
    end
  end

  // Registered read-first data for both ports; START reads back the run flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (busy) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (!in_a) begin
        rdata_a <= '0;
      end else if (bus.i_addr_a == START_W) begin
        rdata_a <= {{(DATA_WIDTH-1){1'b0}}, run};
      end else begin
        rdata_a <= mem[bus.i_addr_a];
      end
      if (!in_b) begin
        rdata_b <= '0;
      end else if (bus.i_addr_b == START_W) begin
        rdata_b <= {{(DATA_WIDTH-1){1'b0}}, run};
      end else begin
        rdata_b <= mem[bus.i_addr_b];
      end
    end
  end

  assign bus.o_data_a    = rdata_a;
  assign bus.o_data_b    = rdata_b;
  assign bus.o_busy      = busy;
  assign bus.o_run       = run;
  assign bus.o_start     = start_pulse;
  assign bus.o_all_done  = all_done;
  assign bus.o_collision = collision;
  assign bus.o_addr_err  = addr_err;

endmodule

// File: tb/tb_env_mailbox_ram.sv
// Directed bench for env_mailbox_ram: a vector table for single-cycle port
// behaviour plus hand-written sequences for sweep length, reset and clear.
module tb_env_mailbox_ram;
  localparam int AW = 12;
  localparam int DW = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   n;

  always #5 clk = ~clk;

  env_mailbox_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  env_mailbox_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  // flags = {run, start, all_done, collision, addr_err}
  typedef struct {
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] data_a;
    logic          we_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] data_b;
    logic          step;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic [4:0]    flags;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                              input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                              input logic st, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                              input logic [4:0] fl);
    vec_t v;
    v.we_a = wa; v.addr_a = aa; v.data_a = da;
    v.we_b = wb; v.addr_b = ab; v.data_b = db;
    v.step = st; v.exp_a = ea; v.exp_b = eb; v.flags = fl;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.i_clear = 1'b0; bus.i_step_done = 1'b0;
    bus.i_we_a = 1'b0; bus.i_addr_a = '0; bus.i_data_a = '0;
    bus.i_we_b = 1'b0; bus.i_addr_b = '0; bus.i_data_b = '0;
  endtask

  task automatic rd2(input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                     input logic [DW-1:0] ea, input logic [DW-1:0] eb, input string nm);
    idle();
    bus.i_addr_a = aa; bus.i_addr_b = ab;
    @(negedge clk);
    check({nm, " port a"}, bus.o_data_a, ea);
    check({nm, " port b"}, bus.o_data_b, eb);
  endtask

  // Counts cycles with o_busy high, starting at the current sample point.
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.o_busy && cnt < 3000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 12'd5,    48'hABCDEF,        1'b0, 12'd5,    48'h0,             1'b0, 48'h0,      48'h0,             5'b00000);
    tbl[1]  = mk(1'b0, 12'd5,    48'h0,             1'b0, 12'd5,    48'h0,             1'b0, 48'hABCDEF, 48'hABCDEF,        5'b00000);
    tbl[2]  = mk(1'b1, 12'd70,   48'h111,           1'b1, 12'd70,   48'h222,           1'b0, 48'h0,      48'h0,             5'b00010);
    tbl[3]  = mk(1'b0, 12'd70,   48'h0,             1'b0, 12'd70,   48'h0,             1'b0, 48'h111,    48'h111,           5'b00000);
    tbl[4]  = mk(1'b1, 12'd67,   48'h1,             1'b0, 12'd67,   48'h0,             1'b0, 48'h0,      48'h0,             5'b11000);
    tbl[5]  = mk(1'b0, 12'd67,   48'h0,             1'b0, 12'd67,   48'h0,             1'b0, 48'h1,      48'h1,             5'b10000);
    tbl[6]  = mk(1'b1, 12'd67,   48'h1,             1'b0, 12'd67,   48'h0,             1'b0, 48'h1,      48'h1,             5'b10000);
    tbl[7]  = mk(1'b0, 12'd67,   48'h0,             1'b0, 12'd0,    48'h0,             1'b1, 48'h1,      48'h0,             5'b00000);
    tbl[8]  = mk(1'b0, 12'd134,  48'h0,             1'b1, 12'd134,  48'hFFFF_FFFF_FFFF, 1'b0, 48'h0,     48'h0,             5'b00000);
    tbl[9]  = mk(1'b0, 12'd134,  48'h0,             1'b1, 12'd135,  48'hFFFF,          1'b0, 48'hFFFF_FFFF_FFFF, 48'h0,     5'b00100);
    tbl[10] = mk(1'b1, 12'd135,  48'hFFF7,          1'b0, 12'd135,  48'h0,             1'b0, 48'hFFFF,   48'hFFFF,          5'b00000);
    tbl[11] = mk(1'b0, 12'd135,  48'h0,             1'b1, 12'd3000, 48'h55,            1'b0, 48'hFFF7,   48'h0,             5'b00001);
    tbl[12] = mk(1'b0, 12'd3000, 48'h0,             1'b0, 12'd5,    48'h0,             1'b0, 48'h0,      48'hABCDEF,        5'b00001);
    tbl[13] = mk(1'b0, 12'd67,   48'h0,             1'b1, 12'd67,   48'h1,             1'b0, 48'h0,      48'h0,             5'b00000);
    tbl[14] = mk(1'b1, 12'd67,   48'h1,             1'b0, 12'd67,   48'h0,             1'b1, 48'h0,      48'h0,             5'b11000);
    tbl[15] = mk(1'b1, 12'd135,  48'hFFFF,          1'b0, 12'd134,  48'h0,             1'b0, 48'hFFF7,   48'hFFFF_FFFF_FFFF, 5'b10000);
    tbl[16] = mk(1'b0, 12'd67,   48'h0,             1'b0, 12'd0,    48'h0,             1'b1, 48'h1,      48'h0,             5'b00000);
    tbl[17] = mk(1'b1, 12'd2599, 48'h1234_5678_9ABC, 1'b1, 12'd0,   48'h42,            1'b0, 48'h0,      48'h0,             5'b00000);
    tbl[18] = mk(1'b0, 12'd0,    48'h0,             1'b0, 12'd2599, 48'h0,             1'b0, 48'h42,     48'h1234_5678_9ABC, 5'b00000);
    tbl[19] = mk(1'b0, 12'd2600, 48'h0,             1'b0, 12'd2599, 48'h0,             1'b0, 48'h0,      48'h1234_5678_9ABC, 5'b00001);

    // Power-on reset values.
    idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset data a", bus.o_data_a, 48'h0);
    check("reset data b", bus.o_data_b, 48'h0);
    check("reset status", {bus.o_busy, bus.o_run, bus.o_start, bus.o_all_done, bus.o_collision, bus.o_addr_err},
          6'b100000);

    // Sweep after reset release.
    rst = 1'b0;
    count_busy(n);
    check("reset sweep length", n, 2600);
    rd2(12'd0, 12'd0, 48'h0, 48'h0, "post-sweep addr 0");
    rd2(12'd1000, 12'd1000, 48'h0, 48'h0, "post-sweep addr 1000");
    rd2(12'd2599, 12'd2599, 48'h0, 48'h0, "post-sweep addr 2599");

    // Single-cycle vector table: drive, one edge, compare.
    for (int i = 0; i < 20; i++) begin
      idle();
      bus.i_we_a = tbl[i].we_a; bus.i_addr_a = tbl[i].addr_a; bus.i_data_a = tbl[i].data_a;
      bus.i_we_b = tbl[i].we_b; bus.i_addr_b = tbl[i].addr_b; bus.i_data_b = tbl[i].data_b;
      bus.i_step_done = tbl[i].step;
      @(negedge clk);
      check($sformatf("vec%0d data a", i), bus.o_data_a, tbl[i].exp_a);
      check($sformatf("vec%0d data b", i), bus.o_data_b, tbl[i].exp_b);
      check($sformatf("vec%0d flags", i),
            {bus.o_run, bus.o_start, bus.o_all_done, bus.o_collision, bus.o_addr_err}, tbl[i].flags);
    end

    // Reset in the middle of a step.
    idle();
    bus.i_we_a = 1'b1; bus.i_addr_a = 12'd67; bus.i_data_a = 48'h1;
    @(negedge clk);
    idle();
    check("mid-step run before reset", bus.o_run, 1'b1);
    rst = 1'b1;
    #1;
    check("mid-step reset status", {bus.o_busy, bus.o_run, bus.o_start, bus.o_all_done, bus.o_collision, bus.o_addr_err},
          6'b100000);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("sweep still busy", bus.o_busy, 1'b1);

    // Reset in the middle of the sweep restarts it from address 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    check("restarted sweep length", n, 2600);

    // i_clear while a step is running.
    idle();
    bus.i_we_a = 1'b1; bus.i_addr_a = 12'd67; bus.i_data_a = 48'h1;
    bus.i_we_b = 1'b1; bus.i_addr_b = 12'd5;  bus.i_data_b = 48'hABCDEF;
    @(negedge clk);
    idle();
    bus.i_we_b = 1'b1; bus.i_addr_b = 12'd2599; bus.i_data_b = 48'h77;
    @(negedge clk);
    idle();
    check("run before clear", bus.o_run, 1'b1);
    rd2(12'd5, 12'd2599, 48'hABCDEF, 48'h77, "data before clear");
    bus.i_clear = 1'b1;
    @(negedge clk);
    idle();
    check("clear run/busy", {bus.o_run, bus.o_busy}, 2'b01);
    count_busy(n);
    check("clear sweep length", n, 2600);
    rd2(12'd5, 12'd2599, 48'h0, 48'h0, "after clear 5/2599");
    rd2(12'd67, 12'd70, 48'h0, 48'h0, "after clear 67/70");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
